// File: rtl/res_station_mc_if.sv
// Reservation-station payload types and the dispatch/CDB/issue bus bundle.
package res_station_mc_pkg;
  localparam int unsigned PREG_W = 7;
  localparam int unsigned ROB_W  = 5;
  localparam int unsigned IMM_W  = 32;
  localparam int unsigned FU_W   = 3;

  typedef struct packed {
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic [PREG_W-1:0] pd_new;
    logic [IMM_W-1:0]  imm;
    logic [FU_W-1:0]   fu;
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [6:0]        func7;
  } rename_data_t;

  typedef struct packed {
    rename_data_t      rn;
    logic [ROB_W-1:0]  rob_idx;
  } rs_data_t;
endpackage

interface res_station_mc_if #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CDB_PORTS = 2
);
  import res_station_mc_pkg::*;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                                di_en;
  rename_data_t                        r_data;
  logic [ROB_W-1:0]                    rob_index_in;
  logic [(1 << PREG_W)-1:0]            preg_rtable;
  logic [CDB_PORTS-1:0]                cdb_valid;
  logic [CDB_PORTS-1:0][PREG_W-1:0]    cdb_tag;
  logic [ROB_W-1:0]                    rob_head;
  logic                                mispredict;
  logic [ROB_W-1:0]                    mispredict_tag;
  logic                                fu_ready;
  logic                                fu_dispatched;
  rs_data_t                            data_out;
  logic                                full;
  logic [CNT_W-1:0]                    count;

  modport master (
    output di_en, r_data, rob_index_in, preg_rtable, cdb_valid, cdb_tag,
           rob_head, mispredict, mispredict_tag, fu_ready,
    input  fu_dispatched, data_out, full, count
  );

  modport slave (
    input  di_en, r_data, rob_index_in, preg_rtable, cdb_valid, cdb_tag,
           rob_head, mispredict, mispredict_tag, fu_ready,
    output fu_dispatched, data_out, full, count
  );
endinterface

// File: rtl/res_station_mc.sv
// Multi-CDB reservation station: dispatch with CDB bypass, parallel wakeup,
// oldest-ready issue by ROB age, selective flush of younger-than-branch ops.
module res_station_mc
  import res_station_mc_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CDB_PORTS = 2
) (
  input logic             clk,
  input logic             reset,
  res_station_mc_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] p1_rdy_q, p1_rdy_d;
  logic [DEPTH-1:0] p2_rdy_q, p2_rdy_d;
  rs_data_t         entry_q [DEPTH];
  rs_data_t         entry_d [DEPTH];
  rs_data_t         data_out_q, data_out_d;
  logic             fu_disp_q, fu_disp_d;
  logic             full_q, full_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0] ready_c;
  logic             accept_c, issue_c;
  logic             free_found_c, sel_found_c;
  logic [IDX_W-1:0] free_idx_c, sel_idx_c;
  logic [ROB_W-1:0] sel_age_c, flush_age_c;

  // Any CDB port broadcasting this tag this cycle.
  function automatic logic cdb_hit(input logic [CDB_PORTS-1:0] v,
                                   input logic [CDB_PORTS-1:0][PREG_W-1:0] t,
                                   input logic [PREG_W-1:0] tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < int'(CDB_PORTS); k++) begin
      if (v[k] && (t[k] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Distance from the ROB head, modulo ROB size; smaller means older.
  function automatic logic [ROB_W-1:0] age(input logic [ROB_W-1:0] idx,
                                           input logic [ROB_W-1:0] head);
    return idx - head;
  endfunction

  // Next-state: wakeup, flush, issue select, dispatch, occupancy.
  always_comb begin
    valid_d      = valid_q;
    p1_rdy_d     = p1_rdy_q;
    p2_rdy_d     = p2_rdy_q;
    entry_d      = entry_q;
    data_out_d   = data_out_q;
    fu_disp_d    = 1'b0;
    free_found_c = 1'b0;
    free_idx_c   = '0;
    sel_found_c  = 1'b0;
    sel_idx_c    = '0;
    sel_age_c    = '0;
    flush_age_c  = age(bus.mispredict_tag, bus.rob_head);
    count_d      = '0;

    ready_c  = valid_q & p1_rdy_q & p2_rdy_q;
    accept_c = bus.di_en & ~full_q & ~bus.mispredict;
    issue_c  = bus.fu_ready & ~bus.mispredict & (|ready_c);

    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!valid_q[i] && !free_found_c) begin
        free_found_c = 1'b1;
        free_idx_c   = IDX_W'(i);
      end
      if (ready_c[i] && (!sel_found_c ||
          (age(entry_q[i].rob_idx, bus.rob_head) < sel_age_c))) begin
        sel_found_c = 1'b1;
        sel_idx_c   = IDX_W'(i);
        sel_age_c   = age(entry_q[i].rob_idx, bus.rob_head);
      end
      if (cdb_hit(bus.cdb_valid, bus.cdb_tag, entry_q[i].rn.ps1)) p1_rdy_d[i] = 1'b1;
      if (cdb_hit(bus.cdb_valid, bus.cdb_tag, entry_q[i].rn.ps2)) p2_rdy_d[i] = 1'b1;
      if (bus.mispredict && valid_q[i] &&
          (age(entry_q[i].rob_idx, bus.rob_head) > flush_age_c)) begin
        valid_d[i] = 1'b0;
      end
    end

    if (issue_c) begin
      valid_d[sel_idx_c] = 1'b0;
      data_out_d         = entry_q[sel_idx_c];
      fu_disp_d          = 1'b1;
    end

    // Slot choice uses registered validity, so a slot freed by issue waits a cycle.
    if (accept_c) begin
      valid_d[free_idx_c]         = 1'b1;
      entry_d[free_idx_c].rn      = bus.r_data;
      entry_d[free_idx_c].rob_idx = bus.rob_index_in;
      p1_rdy_d[free_idx_c] = bus.preg_rtable[bus.r_data.ps1] |
                             cdb_hit(bus.cdb_valid, bus.cdb_tag, bus.r_data.ps1);
      p2_rdy_d[free_idx_c] = bus.preg_rtable[bus.r_data.ps2] |
                             cdb_hit(bus.cdb_valid, bus.cdb_tag, bus.r_data.ps2);
    end

    for (int i = 0; i < int'(DEPTH); i++) begin
      count_d = count_d + CNT_W'(valid_d[i]);
    end
    full_d = (count_d == CNT_W'(DEPTH));
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      p1_rdy_q   <= '0;
      p2_rdy_q   <= '0;
      data_out_q <= '0;
      fu_disp_q  <= 1'b0;
      full_q     <= 1'b0;
      count_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= '0;
    end else begin
      valid_q    <= valid_d;
      p1_rdy_q   <= p1_rdy_d;
      p2_rdy_q   <= p2_rdy_d;
      data_out_q <= data_out_d;
      fu_disp_q  <= fu_disp_d;
      full_q     <= full_d;
      count_q    <= count_d;
      for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= entry_d[i];
    end
  end

  assign bus.fu_dispatched = fu_disp_q;
  assign bus.data_out      = data_out_q;
  assign bus.full          = full_q;
  assign bus.count         = count_q;
endmodule

// File: tb/tb_res_station_mc.sv
// Directed bench for res_station_mc: bypass, fill/full, age wrap, multi-port
// wakeup, selective flush, issue+dispatch collision and mid-run reset.
module tb_res_station_mc;
  import res_station_mc_pkg::*;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  res_station_mc_if #(.DEPTH(8), .CDB_PORTS(2)) bus ();

  res_station_mc #(.DEPTH(8), .CDB_PORTS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.di_en      = 1'b0;
    bus.cdb_valid  = '0;
    bus.mispredict = 1'b0;
    bus.fu_ready   = 1'b0;
  endtask

  task automatic set_op(input logic [4:0] rob, input logic [6:0] ps1, input logic [6:0] ps2);
    bus.di_en          = 1'b1;
    bus.rob_index_in   = rob;
    bus.r_data         = '0;
    bus.r_data.ps1     = ps1;
    bus.r_data.ps2     = ps2;
    bus.r_data.pd_new  = 7'(64 + int'(rob));
    bus.r_data.imm     = 32'hA000_0000 | 32'(rob);
    bus.r_data.opcode  = 7'h33;
  endtask

  task automatic chk_issue(input string tag, input int rob);
    check({tag, " disp"}, 32'(bus.fu_dispatched), 32'd1);
    check({tag, " rob"}, 32'(bus.data_out.rob_idx), 32'(rob));
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    clk                = 1'b0;
    reset              = 1'b0;
    idle();
    bus.r_data         = '0;
    bus.rob_index_in   = '0;
    bus.preg_rtable    = '0;
    bus.cdb_tag        = '0;
    bus.rob_head       = '0;
    bus.mispredict_tag = '0;

    // Reset state
    #3;
    check("rst disp",  32'(bus.fu_dispatched), 32'd0);
    check("rst data",  32'(bus.data_out.rob_idx), 32'd0);
    check("rst imm",   bus.data_out.rn.imm, 32'd0);
    check("rst full",  32'(bus.full), 32'd0);
    check("rst count", 32'(bus.count), 32'd0);
    tick();
    reset = 1'b1;

    // 1: dispatch with same-cycle CDB bypass on ps2 through port 1
    bus.preg_rtable[10] = 1'b1;
    set_op(5'd3, 7'd10, 7'd13);
    bus.cdb_valid  = 2'b10;
    bus.cdb_tag[1] = 7'd13;
    tick();
    check("t1 count", 32'(bus.count), 32'd1);
    check("t1 nodisp", 32'(bus.fu_dispatched), 32'd0);
    idle();
    bus.fu_ready = 1'b1;
    tick();
    chk_issue("t1", 3);
    check("t1 ps2", 32'(bus.data_out.rn.ps2), 32'd13);
    check("t1 count0", 32'(bus.count), 32'd0);
    idle();
    tick();
    check("t1 pulse", 32'(bus.fu_dispatched), 32'd0);
    check("t1 hold", 32'(bus.data_out.rob_idx), 32'd3);

    // 2: fill to full, extra dispatch rejected, drain in age order
    bus.preg_rtable = '1;
    for (int i = 0; i < 8; i++) begin
      set_op(5'(i), 7'd10, 7'(20 + i));
      tick();
    end
    idle();
    check("t2 full", 32'(bus.full), 32'd1);
    check("t2 count", 32'(bus.count), 32'd8);
    set_op(5'd15, 7'd99, 7'd99);
    tick();
    idle();
    check("t2 rej count", 32'(bus.count), 32'd8);
    bus.fu_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_issue($sformatf("t2 i%0d", i), i);
      check($sformatf("t2 ps1 i%0d", i), 32'(bus.data_out.rn.ps1), 32'd10);
    end
    check("t2 empty", 32'(bus.count), 32'd0);
    check("t2 notfull", 32'(bus.full), 32'd0);
    idle();
    tick();

    // 3: ROB wrap, head=30: rob 31 older than rob 1
    bus.rob_head = 5'd30;
    set_op(5'd1, 7'd1, 7'd2);
    tick();
    set_op(5'd31, 7'd1, 7'd2);
    tick();
    idle();
    bus.fu_ready = 1'b1;
    tick();
    chk_issue("t3 first", 31);
    tick();
    chk_issue("t3 second", 1);
    idle();
    tick();

    // 4: multi-port wakeup of waiting entries
    bus.rob_head       = 5'd10;
    bus.preg_rtable    = '0;
    bus.preg_rtable[5] = 1'b1;
    set_op(5'd10, 7'd30, 7'd5); tick();
    set_op(5'd11, 7'd30, 7'd5); tick();
    set_op(5'd12, 7'd30, 7'd5); tick();
    set_op(5'd13, 7'd41, 7'd5); tick();
    idle();
    bus.fu_ready = 1'b1;
    tick();
    check("t4 waiting", 32'(bus.fu_dispatched), 32'd0);
    check("t4 count", 32'(bus.count), 32'd4);
    bus.cdb_valid  = 2'b11;
    bus.cdb_tag[0] = 7'd30;
    bus.cdb_tag[1] = 7'd41;
    tick();
    check("t4 nobypass", 32'(bus.fu_dispatched), 32'd0);
    bus.cdb_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_issue($sformatf("t4 i%0d", i), 10 + i);
    end
    idle();
    tick();
    check("t4 empty", 32'(bus.count), 32'd0);

    // 5: selective flush, dispatch ignored, wakeup still applied
    bus.rob_head    = 5'd0;
    bus.preg_rtable = '0;
    set_op(5'd2, 7'd0, 7'd0); tick();
    set_op(5'd4, 7'd0, 7'd0); tick();
    set_op(5'd6, 7'd0, 7'd0); tick();
    set_op(5'd8, 7'd0, 7'd0); tick();
    set_op(5'd9, 7'd0, 7'd0);
    bus.mispredict     = 1'b1;
    bus.mispredict_tag = 5'd4;
    bus.cdb_valid      = 2'b01;
    bus.cdb_tag[0]     = 7'd0;
    bus.fu_ready       = 1'b1;
    tick();
    check("t5 count", 32'(bus.count), 32'd2);
    check("t5 noissue", 32'(bus.fu_dispatched), 32'd0);
    idle();
    bus.fu_ready = 1'b1;
    tick();
    chk_issue("t5 a", 2);
    tick();
    chk_issue("t5 b", 4);
    tick();
    check("t5 drained", 32'(bus.fu_dispatched), 32'd0);
    check("t5 empty", 32'(bus.count), 32'd0);
    idle();

    // 6: full RS with issue and dispatch in the same cycle
    bus.preg_rtable = '1;
    for (int i = 0; i < 8; i++) begin
      set_op(5'(i), 7'd1, 7'd1);
      tick();
    end
    set_op(5'd8, 7'd1, 7'd1);
    bus.fu_ready = 1'b1;
    tick();
    chk_issue("t6 col", 0);
    check("t6 rej count", 32'(bus.count), 32'd7);
    check("t6 notfull", 32'(bus.full), 32'd0);
    bus.fu_ready = 1'b0;
    tick();
    check("t6 acc count", 32'(bus.count), 32'd8);
    check("t6 full", 32'(bus.full), 32'd1);
    idle();
    bus.fu_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_issue($sformatf("t6 i%0d", i), i);
    end
    idle();
    tick();

    // Reset mid-operation
    set_op(5'd20, 7'd1, 7'd1); tick();
    set_op(5'd21, 7'd1, 7'd1); tick();
    idle();
    bus.fu_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("mrst count", 32'(bus.count), 32'd0);
    check("mrst disp", 32'(bus.fu_dispatched), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("mrst noissue", 32'(bus.fu_dispatched), 32'd0);
    check("mrst empty", 32'(bus.count), 32'd0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
